// File: rtl/debounce_edge.sv
// debounce_edge
// Single-bit line conditioner for slow external serial lines such as PS/2
// clock or data. The raw pin is brought into the clock domain by a
// two-flop synchroniser, then filtered by a saturating run-length counter.
// The cleaned level only follows the line after the line has disagreed with
// it for CYCLES consecutive synchronised samples. Rising and falling
// transitions of the cleaned level are flagged as one-cycle strobes.
//
// Parameters
//   CYCLES       consecutive disagreeing samples needed to change bit_out (>= 1)
//   RESET_LEVEL  reset value of the synchronisers, bit_out and edge history
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   bit_in    in   raw asynchronous line level
//   bit_out   out  debounced level (registered)
//   pos_edge  out  one-cycle strobe, bit_out went 0->1
//   neg_edge  out  one-cycle strobe, bit_out went 1->0
//   any_edge  out  pos_edge | neg_edge
//
// Interface semantics: there is no handshake. The strobes are valid for
// exactly one clock and are not held; the consumer must sample them every
// cycle and cannot stall them.
module debounce_edge #(
  parameter int CYCLES      = 255,
  parameter bit RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  output logic bit_out,
  output logic pos_edge,
  output logic neg_edge,
  output logic any_edge
);

  localparam int            CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(CYCLES - 1);

  // STABLE: counter idle, line agrees with bit_out.
  // COUNTING: counter is running on a disagreeing line.
  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;

  logic          s1;
  logic          s2;
  logic [CW-1:0] count;
  logic          prev;

  logic          differ;
  logic          at_term;
  logic          take;
  logic          cnt_inc;

  assign differ  = s2 ^ bit_out;
  assign at_term = (count == TERM);

  // Synchroniser: only s2 is used downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= bit_in;
      s2 <= s1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= STABLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic. Reaching the terminal count returns to STABLE
  // because bit_out takes the line value on that same edge.
  always_comb begin
    state_next = state;
    case (state)
      STABLE: begin
        if (differ && !at_term) begin
          state_next = COUNTING;
        end
      end
      COUNTING: begin
        if (!differ || at_term) begin
          state_next = STABLE;
        end
      end
      default: state_next = STABLE;
    endcase
  end

  // FSM outputs: datapath controls. With CYCLES == 1 the terminal count is
  // zero, so a single disagreeing sample is taken immediately.
  always_comb begin
    take    = 1'b0;
    cnt_inc = 1'b0;
    if (differ) begin
      if (at_term) begin
        take = 1'b1;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  // Counter, debounced level and edge history. Any agreeing sample clears
  // the counter, so a glitch shorter than CYCLES samples leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      bit_out <= RESET_LEVEL;
      prev    <= RESET_LEVEL;
    end else begin
      prev <= bit_out;
      if (take) begin
        bit_out <= s2;
      end
      if (cnt_inc) begin
        count <= count + CW'(1);
      end else begin
        count <= '0;
      end
    end
  end

  // Reset forces prev == bit_out, so all strobes are low during reset.
  assign pos_edge = bit_out & ~prev;
  assign neg_edge = ~bit_out & prev;
  assign any_edge = bit_out ^ prev;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge. Three instances: CYCLES = 1, 4 and 255 (default).
// Select index: 0 -> CYCLES=1, 1 -> CYCLES=4, 2 -> CYCLES=255.
// Expected edge events {kind, cycle} are queued when stimulus is driven and
// popped by a monitor sampling strobes on the falling clock edge.
module tb_debounce_edge;

  localparam logic [1:0] K_POS = 2'b01;
  localparam logic [1:0] K_NEG = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] bin;
  logic [2:0] bout;
  logic [2:0] pe;
  logic [2:0] ne;
  logic [2:0] ae;

  debounce_edge #(.CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .bit_in(bin[0]), .bit_out(bout[0]),
    .pos_edge(pe[0]), .neg_edge(ne[0]), .any_edge(ae[0])
  );

  debounce_edge #(.CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .bit_in(bin[1]), .bit_out(bout[1]),
    .pos_edge(pe[1]), .neg_edge(ne[1]), .any_edge(ae[1])
  );

  debounce_edge u_dut255 (
    .clk(clk), .reset(reset), .bit_in(bin[2]), .bit_out(bout[2]),
    .pos_edge(pe[2]), .neg_edge(ne[2]), .any_edge(ae[2])
  );

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic push_exp(input int sel, input logic [1:0] kind, input int at);
    logic [31:0] v;
    v = {kind, 30'(at)};
    case (sel)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  // Observe one instance: any strobe activity must match the next expected event.
  task automatic mon(input int sel);
    logic [1:0]  kind;
    logic [31:0] obs;
    logic [31:0] exp;
    kind = {ne[sel], pe[sel]};
    if (kind != 2'b00 || ae[sel]) begin
      check($sformatf("any_edge%0d", sel), 32'(ae[sel]), 32'(pe[sel] | ne[sel]));
      obs = {kind, 30'(cyc)};
      if (qsize(sel) == 0) begin
        check($sformatf("unexpected_edge%0d", sel), obs, 32'h0);
      end else begin
        case (sel)
          0:       exp = exp_q0.pop_front();
          1:       exp = exp_q1.pop_front();
          default: exp = exp_q2.pop_front();
        endcase
        check($sformatf("edge%0d", sel), obs, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      mon(0);
      mon(1);
      mon(2);
    end
  end

  // ---------------- driver tasks (called on a falling edge) ----------------
  task automatic set_in(input int sel, input logic v, output int t);
    bin[sel] = v;
    t = cyc;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int sel, input int budget);
    int k;
    k = 0;
    while (qsize(sel) != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check($sformatf("drain%0d", sel), 32'(qsize(sel)), 32'h0);
    wait_n(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int t1;
    int len;

    reset = 1'b0;
    bin   = 3'b101;

    // Asynchronous reset, no clock edge yet.
    #3 reset = 1'b1;
    #1;
    check("rst_async_bit_out", 32'(bout), 32'h7);
    check("rst_async_strobes", 32'(pe | ne | ae), 32'h0);
    wait_n(3);
    check("rst_held_bit_out", 32'(bout), 32'h7);
    reset = 1'b0;
    t0 = cyc;
    push_exp(1, K_NEG, t0 + 6);
    drain(1, 50);
    check("after_rst_fall", 32'(bout[1]), 32'h0);

    // Rising edge from 0.
    set_in(1, 1'b1, t0);
    push_exp(1, K_POS, t0 + 6);
    drain(1, 50);
    check("rise_level", 32'(bout[1]), 32'h1);

    // Glitch of CYCLES-1 samples is rejected.
    set_in(1, 1'b0, t0);
    wait_n(3);
    set_in(1, 1'b1, t1);
    wait_n(20);
    check("glitch3_level", 32'(bout[1]), 32'h1);

    // Pulse of exactly CYCLES samples propagates.
    set_in(1, 1'b0, t0);
    push_exp(1, K_NEG, t0 + 6);
    wait_n(4);
    set_in(1, 1'b1, t1);
    push_exp(1, K_POS, t1 + 6);
    wait_n(20);
    drain(1, 20);

    // Six-clock low pulse.
    set_in(1, 1'b0, t0);
    push_exp(1, K_NEG, t0 + 6);
    wait_n(6);
    set_in(1, 1'b1, t1);
    push_exp(1, K_POS, t1 + 6);
    wait_n(20);
    drain(1, 20);

    // Bounce: toggle every clock for 20 clocks, then hold low.
    for (int i = 0; i < 20; i++) begin
      set_in(1, (i % 2 == 0) ? 1'b0 : 1'b1, t1);
      wait_n(1);
    end
    set_in(1, 1'b0, t0);
    push_exp(1, K_NEG, t0 + 6);
    wait_n(30);
    check("bounce_level", 32'(bout[1]), 32'h0);
    drain(1, 10);
    set_in(1, 1'b1, t0);
    push_exp(1, K_POS, t0 + 6);
    drain(1, 50);

    // Random-length low pulses.
    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(1, 8);
      set_in(1, 1'b0, t0);
      if (len >= 4) push_exp(1, K_NEG, t0 + 6);
      wait_n(len);
      set_in(1, 1'b1, t1);
      if (len >= 4) push_exp(1, K_POS, t1 + 6);
      wait_n(12);
    end
    drain(1, 20);

    // Reset while the counter sits at 2: progress is discarded.
    set_in(1, 1'b0, t0);
    wait_n(4);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_bit_out", 32'(bout), 32'h7);
    check("rst_mid_strobes", 32'(pe | ne | ae), 32'h0);
    wait_n(2);
    reset = 1'b0;
    t1 = cyc;
    push_exp(1, K_NEG, t1 + 6);
    drain(1, 50);
    set_in(1, 1'b1, t0);
    push_exp(1, K_POS, t0 + 6);
    drain(1, 50);

    // CYCLES = 255: 254-clock pulse ignored.
    set_in(2, 1'b0, t0);
    wait_n(254);
    set_in(2, 1'b1, t1);
    wait_n(300);
    check("c255_short_level", 32'(bout[2]), 32'h1);

    // CYCLES = 255: 257-clock pulse gives neg then pos, 257 clocks apart.
    set_in(2, 1'b0, t0);
    push_exp(2, K_NEG, t0 + 257);
    wait_n(257);
    set_in(2, 1'b1, t1);
    push_exp(2, K_POS, t1 + 257);
    drain(2, 600);
    check("c255_final_level", 32'(bout[2]), 32'h1);

    // CYCLES = 1: a single-cycle pulse passes.
    set_in(0, 1'b0, t0);
    push_exp(0, K_NEG, t0 + 3);
    wait_n(1);
    set_in(0, 1'b1, t1);
    push_exp(0, K_POS, t1 + 3);
    drain(0, 20);
    check("c1_final_level", 32'(bout[0]), 32'h1);

    check("final_q0", 32'(qsize(0)), 32'h0);
    check("final_q1", 32'(qsize(1)), 32'h0);
    check("final_q2", 32'(qsize(2)), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
